axi_led_pwm_m: RTL and testbench



---
 rtl/axi_led_pkg.sv | 40 ++++
 rtl/led_chan_m.sv | 36 +++
 rtl/axi_led_pwm_m.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_led_pwm_m.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_led_pkg.sv
// Shared types and constants for the AXI3 LED/PWM peripheral.
package axi_led_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeOn    = 2'd1,
        ModeBlink = 2'd2,
        ModePwm   = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_e;

    typedef enum logic {
        RIdle,
        RData
    } rd_state_e;

    // Word indices (byte address >> 2)
    localparam logic [9:0] REG_CFG     = 10'h000;
    localparam logic [9:0] REG_ID      = 10'h001;
    localparam logic [9:0] REG_CH_BASE = 10'h040;
    localparam logic [9:0] REG_STAT    = 10'h080;

    localparam logic [15:0] ID_MAGIC    = 16'h1ED0;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/led_chan_m.sv
// One LED channel: mode mux over the shared PWM counter, registered output.
module led_chan_m
    import axi_led_pkg::*;
#(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  led_mode_e        mode,
    input  logic [PWM_W-1:0] duty,
    input  logic [PWM_W-1:0] cnt,
    output logic             led
);

    logic led_d;

    always_comb begin
        led_d = 1'b0;
        case (mode)
            ModeOff:   led_d = 1'b0;
            ModeOn:    led_d = 1'b1;
            ModeBlink: led_d = ~cnt[PWM_W-1];
            ModePwm:   led_d = (cnt < duty);
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: rtl/axi_led_pwm_m.sv
// AXI3 slave exposing per-channel LED modes (off/on/blink/pwm) over a prescaled timebase.
module axi_led_pwm_m
    import axi_led_pkg::*;
#(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic            i_clk0,
    input  logic            i_rst,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [11:0]     i_awid,
    input  logic [11:0]     i_awaddr,
    input  logic [3:0]      i_awlen,
    input  logic            i_wvalid,
    output logic            o_wready,
    input  logic            i_wlast,
    input  logic [31:0]     i_wdata,
    input  logic [3:0]      i_wstrb,
    output logic            o_bvalid,
    input  logic            i_bready,
    output logic [11:0]     o_bid,
    output logic [1:0]      o_bresp,
    input  logic            i_arvalid,
    output logic            o_arready,
    input  logic [11:0]     i_arid,
    input  logic [11:0]     i_araddr,
    input  logic [3:0]      i_arlen,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [11:0]     o_rid,
    output logic [31:0]     o_rdata,
    output logic [1:0]      o_rresp,
    output logic            o_rlast,
    output logic [N_CH-1:0] o_led
);

    localparam logic [31:0] ID_WORD = {ID_MAGIC, 8'(PWM_W), 8'(N_CH)};

    wr_state_e        wst_q;
    logic             awready_q, wready_q, bvalid_q, werr_q;
    logic [11:0]      bid_q;
    logic [1:0]       bresp_q;
    logic [9:0]       waddr_q;

    rd_state_e        rdst_q;
    logic             arready_q, rvalid_q, rlast_q;
    logic [11:0]      rid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [3:0]       rlen_q, rbeat_q, rbeat_nxt;

    logic [PRESCALE_W-1:0] cfg_q, presc_q;
    logic [PWM_W-1:0]      cnt_q;
    led_mode_e             ch_mode_q [N_CH];
    logic [PWM_W-1:0]      ch_duty_q [N_CH];
    logic [N_CH-1:0]       led;

    logic [9:0]  ar_idx;
    logic [31:0] rd_word, wr_old, wr_new;
    logic        rd_ok, wr_fire;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^{i_awaddr[1:0], i_araddr[1:0]};
    assign ar_idx          = i_araddr[11:2];
    assign rbeat_nxt       = rbeat_q + 4'd1;

    function automatic logic is_ch(input logic [9:0] idx);
        return (idx >= REG_CH_BASE) && (idx < REG_CH_BASE + 10'(N_CH));
    endfunction

    // ---------------- read decode (sampled at AR handshake)
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        if (ar_idx == REG_CFG) begin
            rd_word = 32'(cfg_q);
        end else if (ar_idx == REG_ID) begin
            rd_word = ID_WORD;
        end else if (ar_idx == REG_STAT) begin
            rd_word = 32'(led);
        end else if (is_ch(ar_idx)) begin
            for (int n = 0; n < N_CH; n++) begin
                if (ar_idx == REG_CH_BASE + 10'(n)) begin
                    rd_word = 32'({ch_duty_q[n], 6'b0, ch_mode_q[n]});
                end
            end
        end else begin
            rd_ok = 1'b0;
        end
    end

    // ---------------- write merge: byte lanes over the current register image
    always_comb begin
        wr_old = '0;
        if (waddr_q == REG_CFG) begin
            wr_old = 32'(cfg_q);
        end
        for (int n = 0; n < N_CH; n++) begin
            if (waddr_q == REG_CH_BASE + 10'(n)) begin
                wr_old = 32'({ch_duty_q[n], 6'b0, ch_mode_q[n]});
            end
        end
        wr_new = (wr_old & ~strb_mask(i_wstrb)) | (i_wdata & strb_mask(i_wstrb));
    end

    assign wr_fire = (wst_q == WData) && i_wvalid && wready_q && !werr_q;

    // ---------------- write FSM
    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            wst_q     <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (wst_q)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (i_awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        waddr_q   <= i_awaddr[11:2];
                        bid_q     <= i_awid;
                        werr_q    <= (i_awlen != 4'd0) ||
                                     !((i_awaddr[11:2] == REG_CFG) || is_ch(i_awaddr[11:2]));
                        wst_q     <= WData;
                    end
                end
                WData: begin
                    if (i_wvalid && wready_q && i_wlast) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= werr_q ? RESP_SLVERR : RESP_OKAY;
                        wst_q    <= WResp;
                    end
                end
                WResp: begin
                    if (i_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wst_q     <= WIdle;
                    end
                end
                default: wst_q <= WIdle;
            endcase
        end
    end

    // ---------------- register file
    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            cfg_q <= '0;
            for (int n = 0; n < N_CH; n++) begin
                ch_mode_q[n] <= ModeOff;
                ch_duty_q[n] <= '0;
            end
        end else if (wr_fire) begin
            if (waddr_q == REG_CFG) begin
                cfg_q <= wr_new[PRESCALE_W-1:0];
            end
            for (int n = 0; n < N_CH; n++) begin
                if (waddr_q == REG_CH_BASE + 10'(n)) begin
                    ch_mode_q[n] <= led_mode_e'(wr_new[1:0]);
                    ch_duty_q[n] <= wr_new[8 +: PWM_W];
                end
            end
        end
    end

    // ---------------- read FSM
    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            rdst_q    <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlen_q    <= '0;
            rbeat_q   <= '0;
        end else begin
            case (rdst_q)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (i_arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= i_arid;
                        rlen_q    <= i_arlen;
                        rbeat_q   <= '0;
                        rlast_q   <= (i_arlen == 4'd0);
                        if ((i_arlen == 4'd0) && rd_ok) begin
                            rdata_q <= rd_word;
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                        rdst_q <= RData;
                    end
                end
                RData: begin
                    if (i_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rdst_q    <= RIdle;
                        end else begin
                            rbeat_q <= rbeat_nxt;
                            rlast_q <= (rbeat_nxt == rlen_q);
                        end
                    end
                end
                default: rdst_q <= RIdle;
            endcase
        end
    end

    // ---------------- timebase: new CFG is only picked up at the next reload
    always_ff @(posedge i_clk0 or negedge i_rst) begin
        if (!i_rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (presc_q == '0) begin
            presc_q <= cfg_q;
            cnt_q   <= cnt_q + PWM_W'(1);
        end else begin
            presc_q <= presc_q - PRESCALE_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        led_chan_m #(
            .PWM_W (PWM_W)
        ) u_chan (
            .clk   (i_clk0),
            .rst_n (i_rst),
            .mode  (ch_mode_q[g]),
            .duty  (ch_duty_q[g]),
            .cnt   (cnt_q),
            .led   (led[g])
        );
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign o_arready = arready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rid     = rid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;
    assign o_rlast   = rlast_q;
    assign o_led     = led;

endmodule

// File: tb/tb_axi_led_pwm_m.sv
// Randomized bench for axi_led_pwm_m against a register-level reference model.
module tb_axi_led_pwm_m;

    localparam int TMO = 200;

    logic        i_clk0 = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_awvalid = 0, i_wvalid = 0, i_wlast = 0, i_bready = 0;
    logic        i_arvalid = 0, i_rready = 0;
    logic [11:0] i_awid = 0, i_awaddr = 0, i_arid = 0, i_araddr = 0;
    logic [3:0]  i_awlen = 0, i_arlen = 0, i_wstrb = 0;
    logic [31:0] i_wdata = 0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
    logic [11:0] o_bid, o_rid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;
    logic [7:0]  o_led;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_cfg;
    logic [31:0] m_ch [8];

    always #5 i_clk0 = ~i_clk0;

    axi_led_pwm_m dut (
        .i_clk0    (i_clk0),    .i_rst     (i_rst),
        .i_awvalid (i_awvalid), .o_awready (o_awready), .i_awid (i_awid),
        .i_awaddr  (i_awaddr),  .i_awlen   (i_awlen),
        .i_wvalid  (i_wvalid),  .o_wready  (o_wready),  .i_wlast (i_wlast),
        .i_wdata   (i_wdata),   .i_wstrb   (i_wstrb),
        .o_bvalid  (o_bvalid),  .i_bready  (i_bready),  .o_bid (o_bid), .o_bresp (o_bresp),
        .i_arvalid (i_arvalid), .o_arready (o_arready), .i_arid (i_arid),
        .i_araddr  (i_araddr),  .i_arlen   (i_arlen),
        .o_rvalid  (o_rvalid),  .i_rready  (i_rready),  .o_rid (o_rid),
        .o_rdata   (o_rdata),   .o_rresp   (o_rresp),   .o_rlast (o_rlast),
        .o_led     (o_led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model
    task automatic model_reset();
        m_cfg = 0;
        for (int n = 0; n < 8; n++) m_ch[n] = 0;
    endtask

    function automatic bit is_wr(input logic [11:0] a);
        int idx = int'(a[11:2]);
        return idx == 0 || (idx >= 64 && idx < 72);
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int idx = int'(a[11:2]);
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        if (idx == 0) m_cfg = ((m_cfg & ~mask) | (d & mask)) & 32'h0000_FFFF;
        else if (idx >= 64 && idx < 72)
            m_ch[idx-64] = ((m_ch[idx-64] & ~mask) | (d & mask)) & 32'h0000_FF03;
    endtask

    // known: which data bits the model can predict (STAT bits of blink/pwm channels are not)
    task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                              output logic [31:0] known);
        int idx = int'(a[11:2]);
        d = 0; r = 2'b00; known = 32'hFFFF_FFFF;
        if (idx == 0) d = m_cfg;
        else if (idx == 1) d = 32'h1ED0_0808;
        else if (idx >= 64 && idx < 72) d = m_ch[idx-64];
        else if (idx == 128) begin
            for (int n = 0; n < 8; n++) begin
                if (m_ch[n][1:0] == 2'd1) d[n] = 1'b1;
                else if (m_ch[n][1:0] != 2'd0) known[n] = 1'b0;
            end
        end else r = 2'b10;
    endtask

    // ---------------- bus tasks (drive and sample on negedge)
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [3:0] len, input int bdelay, output logic [1:0] resp);
        int n;
        bit stable;
        logic [11:0] id;
        id = 12'($urandom);
        i_awvalid = 1; i_awaddr = a; i_awlen = len; i_awid = id;
        n = 0;
        while (!o_awready && n < TMO) begin @(negedge i_clk0); n++; end
        if (n >= TMO) check_eq("aw_timeout", 1, 0);
        @(negedge i_clk0);
        i_awvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            i_wvalid = 1; i_wdata = d; i_wstrb = s; i_wlast = (b == int'(len));
            n = 0;
            while (!o_wready && n < TMO) begin @(negedge i_clk0); n++; end
            if (n >= TMO) check_eq("w_timeout", 1, 0);
            @(negedge i_clk0);
        end
        i_wvalid = 0; i_wlast = 0;
        check_eq("b_latency", o_bvalid, 1);
        resp = o_bresp;
        if (bdelay > 0) begin
            stable = 1;
            repeat (bdelay) begin
                @(negedge i_clk0);
                if (!o_bvalid || o_bresp !== resp || o_bid !== id) stable = 0;
            end
            check_eq("b_hold", stable, 1);
        end
        i_bready = 1;
        n = 0;
        while (!o_bvalid && n < TMO) begin @(negedge i_clk0); n++; end
        if (n >= TMO) check_eq("b_timeout", 1, 0);
        resp = o_bresp;
        check_eq("bid", o_bid, id);
        @(negedge i_clk0);
        i_bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [3:0] len,
                            output logic [31:0] d, output logic [1:0] resp);
        int n;
        logic [11:0] id;
        id = 12'($urandom);
        i_arvalid = 1; i_araddr = a; i_arlen = len; i_arid = id;
        n = 0;
        while (!o_arready && n < TMO) begin @(negedge i_clk0); n++; end
        if (n >= TMO) check_eq("ar_timeout", 1, 0);
        @(negedge i_clk0);
        i_arvalid = 0;
        i_rready = 1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!o_rvalid && n < TMO) begin @(negedge i_clk0); n++; end
            if (n >= TMO) check_eq("r_timeout", 1, 0);
            if (b == 0) begin d = o_rdata; resp = o_rresp; end
            if (len != 0) check_eq("burst_rdata", o_rdata, 0);
            check_eq("rlast", o_rlast, (b == int'(len)) ? 1 : 0);
            check_eq("rid", o_rid, id);
            @(negedge i_clk0);
        end
        i_rready = 0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, exp_d, known;
        logic [1:0]  r, exp_r;
        logic [11:0] pool [14];
        logic [11:0] a;
        int n, hi, ch, duty;
        logic prev;

        model_reset();
        pool = '{12'h000, 12'h004, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'h114,
                 12'h118, 12'h11C, 12'h124, 12'h200, 12'h300, 12'h008};

        // reset state
        repeat (3) @(negedge i_clk0);
        check_eq("rst_awready", o_awready, 0);
        check_eq("rst_arready", o_arready, 0);
        check_eq("rst_valids", {o_bvalid, o_rvalid, o_wready}, 0);
        check_eq("rst_led", o_led, 0);
        i_rst = 1;
        #1 check_eq("awready_still_low", o_awready, 0);
        @(posedge i_clk0);
        #1 check_eq("awready_rise", o_awready, 1);
        check_eq("arready_rise", o_arready, 1);
        @(negedge i_clk0);

        axi_read(12'h004, 0, d, r);
        check_eq("id_data", d, 32'h1ED0_0808);
        check_eq("id_resp", r, 2'b00);

        // on + pwm channels
        axi_write(12'h100, 32'h1, 4'hF, 0, 0, r);
        check_eq("ch0_resp", r, 2'b00);
        check_eq("ch0_led_latency", o_led[0], 1);
        model_write(12'h100, 32'h1, 4'hF);
        axi_write(12'h104, 32'h4003, 4'hF, 0, 0, r);
        model_write(12'h104, 32'h4003, 4'hF);
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, r);
        check_eq("cfg_resp", r, 2'b00);
        repeat (3) @(negedge i_clk0);
        hi = 0;
        repeat (256) begin hi += int'(o_led[1]); @(negedge i_clk0); end
        check_eq("pwm_0x40", hi, 64);

        // blink with prescale 3
        axi_write(12'h108, 32'h2, 4'hF, 0, 0, r);
        model_write(12'h108, 32'h2, 4'hF);
        axi_write(12'h000, 32'h3, 4'hF, 0, 0, r);
        model_write(12'h000, 32'h3, 4'hF);
        prev = o_led[2]; n = 0;
        while (o_led[2] == prev && n < 1100) begin @(negedge i_clk0); n++; end
        check_eq("blink_edge_seen", (n < 1100) ? 1 : 0, 1);
        prev = o_led[2]; n = 0;
        while (o_led[2] == prev && n < 1100) begin @(negedge i_clk0); n++; end
        check_eq("blink_half_period", n, 512);
        axi_read(12'h200, 0, d, r);
        model_read(12'h200, exp_d, exp_r, known);
        check_eq("stat_known", d & known, exp_d & known);

        // error cases
        axi_write(12'h300, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        check_eq("unmapped_wr_resp", r, 2'b10);
        axi_read(12'h124, 0, d, r);
        check_eq("ch9_rd_resp", r, 2'b10);
        check_eq("ch9_rd_data", d, 0);
        axi_write(12'h004, 32'h0, 4'hF, 0, 0, r);
        check_eq("id_wr_resp", r, 2'b10);
        axi_read(12'h004, 0, d, r);
        check_eq("id_after_wr", d, 32'h1ED0_0808);
        axi_read(12'h100, 0, d, r);
        check_eq("ch0_unchanged", d, m_ch[0]);

        // bursts
        axi_write(12'h10C, 32'h0000_FF03, 4'hF, 3, 10, r);
        check_eq("burst_wr_resp", r, 2'b10);
        axi_read(12'h10C, 0, d, r);
        check_eq("ch3_not_written", d, 0);
        axi_read(12'h100, 2, d, r);
        check_eq("burst_rd_resp", r, 2'b10);

        // randomized register traffic
        for (int it = 0; it < 60; it++) begin
            a = pool[$urandom_range(0, 13)] | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                if (a[11:2] == 10'h000) d = d & 32'h7;
                i_wstrb = 4'($urandom);
                exp_r = is_wr(a) ? 2'b00 : 2'b10;
                axi_write(a, d, i_wstrb, 0, 0, r);
                if (is_wr(a)) model_write(a, d, i_wstrb);
                check_eq("rnd_wr_resp", r, exp_r);
            end else begin
                axi_read(a, 0, d, r);
                model_read(a, exp_d, exp_r, known);
                check_eq("rnd_rd_data", d & known, exp_d & known);
                check_eq("rnd_rd_resp", r, exp_r);
            end
            repeat (3) @(negedge i_clk0);
        end

        // randomized pwm duty at full rate
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, r);
        model_write(12'h000, 32'h0, 4'hF);
        repeat (12) @(negedge i_clk0);
        for (int it = 0; it < 3; it++) begin
            ch = $urandom_range(0, 7);
            duty = $urandom_range(0, 255);
            axi_write(12'h100 + 12'(4 * ch), 32'(duty << 8) | 32'h3, 4'hF, 0, 0, r);
            model_write(12'h100 + 12'(4 * ch), 32'(duty << 8) | 32'h3, 4'hF);
            repeat (3) @(negedge i_clk0);
            hi = 0;
            repeat (256) begin hi += int'(o_led[ch]); @(negedge i_clk0); end
            check_eq("rnd_pwm_duty", hi, duty);
        end

        // reset between AW and W
        i_awvalid = 1; i_awaddr = 12'h100; i_awlen = 0; i_awid = 12'h5A5;
        n = 0;
        while (!o_awready && n < TMO) begin @(negedge i_clk0); n++; end
        @(negedge i_clk0);
        i_awvalid = 0;
        i_rst = 0;
        #1 check_eq("midrst_led", o_led, 0);
        check_eq("midrst_bvalid", o_bvalid, 0);
        repeat (2) @(negedge i_clk0);
        i_rst = 1;
        model_reset();
        repeat (2) @(negedge i_clk0);
        check_eq("midrst_no_b", o_bvalid, 0);
        axi_write(12'h100, 32'h1, 4'hF, 0, 0, r);
        model_write(12'h100, 32'h1, 4'hF);
        check_eq("post_rst_wr_resp", r, 2'b00);
        repeat (2) @(negedge i_clk0);
        check_eq("post_rst_led", o_led, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
